// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and defaults for the memory arbiter
package memory_arbiter_pkg;

  localparam int MAX_WAIT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IREQ = 2'd1,
    ST_DREQ = 2'd2
  } arb_state_e;

  // Snapshot of one memory access, frozen for its whole duration.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] store;
    logic        wr;
  } access_t;

  function automatic int cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - busy-cycle watchdog for a single memory access
module wait_timer
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = cnt_width(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the busy cycle that would bring the tally up to MAX_WAIT.
  assign expire_o = enable_i && (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter, data before instruction, with watchdog
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic        ram_busy,
  input  logic [31:0] ram_load,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  output logic        i_ready,
  output logic        d_ready,
  output logic [31:0] imemload,
  output logic [31:0] dmmload,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  access_t     acc_q, acc_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmmload_q, dmmload_d;
  logic        bus_err_q, bus_err_d;

  logic        d_req;
  access_t     d_acc;
  access_t     i_acc;
  logic        busy_cycle;
  logic        timer_clear;
  logic        timer_expire;
  logic        done;

  assign d_req = dmmRen | dmmWen;
  // A simultaneous read and write request is served as a write.
  assign d_acc = {dmmaddr, dmmstore, dmmWen};
  assign i_acc = {imemaddr, 32'h0, 1'b0};

  assign busy_cycle  = (state_q != ST_IDLE) && ram_busy;
  assign timer_clear = (state_d != state_q);
  assign done        = (state_q != ST_IDLE) && (!ram_busy || timer_expire);

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .clear_i (timer_clear),
    .enable_i(busy_cycle),
    .expire_o(timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    imemload_d = imemload_q;
    dmmload_d  = dmmload_q;
    bus_err_d  = bus_err_q | timer_expire;

    unique case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          state_d = ST_DREQ;
          acc_d   = d_acc;
        end else if (imemRen) begin
          state_d = ST_IREQ;
          acc_d   = i_acc;
        end
      end
      ST_IREQ: begin
        if (done) begin
          i_ready_d  = 1'b1;
          imemload_d = timer_expire ? 32'h0 : ram_load;
          // Chain straight into a pending data access to avoid an idle bubble.
          if (d_req && !timer_expire) begin
            state_d = ST_DREQ;
            acc_d   = d_acc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DREQ: begin
        if (done) begin
          d_ready_d = 1'b1;
          state_d   = ST_IDLE;
          if (timer_expire) begin
            dmmload_d = 32'h0;
          end else if (!acc_q.wr) begin
            dmmload_d = ram_load;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      imemload_q <= 32'h0;
      dmmload_q  <= 32'h0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      imemload_q <= imemload_d;
      dmmload_q  <= dmmload_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign ram_ren   = (state_q == ST_IREQ) || ((state_q == ST_DREQ) && !acc_q.wr);
  assign ram_wen   = (state_q == ST_DREQ) && acc_q.wr;
  assign ram_addr  = (state_q != ST_IDLE) ? acc_q.addr : 32'h0;
  assign ram_store = (state_q != ST_IDLE) ? acc_q.store : 32'h0;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign imemload  = imemload_q;
  assign dmmload   = dmmload_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed vector bench for memory_arbiter
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen, dmmWen;
  logic [31:0] dmmaddr, dmmstore;
  logic        ram_busy;
  logic [31:0] ram_load;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  logic        i_ready, d_ready;
  logic [31:0] imemload, dmmload;
  logic        bus_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.MAX_WAIT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemRen  (imemRen),
    .imemaddr (imemaddr),
    .dmmRen   (dmmRen),
    .dmmWen   (dmmWen),
    .dmmaddr  (dmmaddr),
    .dmmstore (dmmstore),
    .ram_busy (ram_busy),
    .ram_load (ram_load),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_store(ram_store),
    .i_ready  (i_ready),
    .d_ready  (d_ready),
    .imemload (imemload),
    .dmmload  (dmmload),
    .bus_err  (bus_err)
  );

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] ds;
    logic        busy;
    logic [31:0] ld;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_ir;
    logic        e_dr;
    logic [31:0] e_il;
    logic [31:0] e_dl;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] ds, input logic busy, input logic [31:0] ld,
    input logic e_ren, input logic e_wen, input logic [31:0] e_addr, input logic [31:0] e_store,
    input logic e_ir, input logic e_dr, input logic [31:0] e_il, input logic [31:0] e_dl,
    input logic e_err);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds;
    v.busy = busy; v.ld = ld;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_il = e_il; v.e_dl = e_dl; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input logic busy,
                       input logic [31:0] ld);
    imemRen = ir; imemaddr = ia; dmmRen = dr; dmmWen = dw;
    dmmaddr = da; dmmstore = ds; ram_busy = busy; ram_load = ld;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},   {31'h0, ram_ren},  32'h0);
    chk({tag, "_wen"},   {31'h0, ram_wen},  32'h0);
    chk({tag, "_addr"},  ram_addr,          32'h0);
    chk({tag, "_store"}, ram_store,         32'h0);
    chk({tag, "_irdy"},  {31'h0, i_ready},  32'h0);
    chk({tag, "_drdy"},  {31'h0, d_ready},  32'h0);
    chk({tag, "_iload"}, imemload,          32'h0);
    chk({tag, "_dload"}, dmmload,           32'h0);
    chk({tag, "_err"},   {31'h0, bus_err},  32'h0);
  endtask

  localparam logic [31:0] IL1 = 32'h00500093;
  localparam logic [31:0] IL2 = 32'hBBBB0002;
  localparam logic [31:0] IL3 = 32'hCCCC0003;
  localparam logic [31:0] DL1 = 32'hAAAA0001;
  localparam logic [31:0] DL2 = 32'hDDDD0004;

  initial begin
    int          ren_cycles;
    bit          seen;
    logic [31:0] got_il;
    logic        got_err, got_ren;

    // Each row: inputs for this cycle, outputs expected just before the next edge.
    vecs.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, IL1,  0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, IL1,  1, 0, 'h100, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 'h2000, 'hDEADBEEF, 1, 0,  0, 0, 0, 0,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h3000, 'h11111111, 1, 0,  0, 1, 'h2000, 'hDEADBEEF,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h3000, 'h11111111, 1, 0,  0, 1, 'h2000, 'hDEADBEEF,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h3000, 'h11111111, 1, 0,  0, 1, 'h2000, 'hDEADBEEF,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h3000, 'h11111111, 0, 'hCAFEF00D,  0, 1, 'h2000, 'hDEADBEEF,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, IL1, 0, 0));
    vecs.push_back(mk(1, 'h400, 1, 0, 'h500, 0, 0, DL1,  0, 0, 0, 0,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(1, 'h400, 0, 0, 0, 0, 0, DL1,  1, 0, 'h500, 0,  0, 0, IL1, 0, 0));
    vecs.push_back(mk(1, 'h400, 0, 0, 0, 0, 0, IL2,  0, 0, 0, 0,  0, 1, IL1, DL1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, IL2,  1, 0, 'h400, 0,  0, 0, IL1, DL1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, IL2, DL1, 0));
    vecs.push_back(mk(1, 'h600, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, IL2, DL1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h700, 0, 1, 0,  1, 0, 'h600, 0,  0, 0, IL2, DL1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h700, 0, 1, 0,  1, 0, 'h600, 0,  0, 0, IL2, DL1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 'h700, 0, 0, IL3,  1, 0, 'h600, 0,  0, 0, IL2, DL1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, DL2,  1, 0, 'h700, 0,  1, 0, IL3, DL1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, IL3, DL2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 'h800, 'h12345678, 0, 'hEEEE0005,  0, 0, 0, 0,  0, 0, IL3, DL2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'hEEEE0005,  0, 1, 'h800, 'h12345678,  0, 0, IL3, DL2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, IL3, DL2, 0));

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset");
    @(posedge CLK); #1;
    nRST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].ds, vecs[i].busy, vecs[i].ld);
      @(negedge CLK);
      chk($sformatf("r%0d_ren", i),   {31'h0, ram_ren}, {31'h0, vecs[i].e_ren});
      chk($sformatf("r%0d_wen", i),   {31'h0, ram_wen}, {31'h0, vecs[i].e_wen});
      chk($sformatf("r%0d_addr", i),  ram_addr,         vecs[i].e_addr);
      chk($sformatf("r%0d_store", i), ram_store,        vecs[i].e_store);
      chk($sformatf("r%0d_irdy", i),  {31'h0, i_ready}, {31'h0, vecs[i].e_ir});
      chk($sformatf("r%0d_drdy", i),  {31'h0, d_ready}, {31'h0, vecs[i].e_dr});
      chk($sformatf("r%0d_iload", i), imemload,         vecs[i].e_il);
      chk($sformatf("r%0d_dload", i), dmmload,          vecs[i].e_dl);
      chk($sformatf("r%0d_err", i),   {31'h0, bus_err}, {31'h0, vecs[i].e_err});
      @(posedge CLK); #1;
    end

    // Watchdog: memory never answers, MAX_WAIT = 4.
    drive(1, 'h900, 0, 0, 0, 0, 1, 0);
    ren_cycles = 0;
    seen = 0;
    got_il = 32'hFFFFFFFF;
    got_err = 1'b0;
    got_ren = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (i_ready) begin
        seen = 1;
        got_il = imemload;
        got_err = bus_err;
        got_ren = ram_ren;
      end else if (ram_ren) begin
        ren_cycles++;
      end
      @(posedge CLK); #1;
      imemRen = 1'b0;
    end
    chk("wd_ready_seen", {31'h0, seen},    32'h1);
    chk("wd_ren_cycles", ren_cycles,       32'd4);
    chk("wd_iload_zero", got_il,           32'h0);
    chk("wd_err_set",    {31'h0, got_err}, 32'h1);
    chk("wd_ren_drop",   {31'h0, got_ren}, 32'h0);

    // bus_err stays set across a later successful access.
    drive(1, 'h904, 0, 0, 0, 0, 0, 32'h77770007);
    @(posedge CLK); #1;
    imemRen = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("sticky_irdy",  {31'h0, i_ready}, 32'h1);
    chk("sticky_iload", imemload,         32'h77770007);
    chk("sticky_err",   {31'h0, bus_err}, 32'h1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of a data read.
    drive(0, 0, 1, 0, 'hB00, 0, 1, 0);
    @(posedge CLK); #1;
    dmmRen = 1'b0;
    @(negedge CLK);
    chk("mid_ren",  {31'h0, ram_ren}, 32'h1);
    chk("mid_addr", ram_addr,         32'hB00);
    #2;
    nRST = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge CLK); #1;
    drive(1, 'hA00, 0, 0, 0, 0, 0, 32'h0F0F0F0F);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_idle_ren", {31'h0, ram_ren}, 32'h0);
    @(posedge CLK); #1;
    imemRen = 1'b0;
    @(negedge CLK);
    chk("post_ren",  {31'h0, ram_ren}, 32'h1);
    chk("post_addr", ram_addr,         32'hA00);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("post_irdy",  {31'h0, i_ready}, 32'h1);
    chk("post_drdy",  {31'h0, d_ready}, 32'h0);
    chk("post_iload", imemload,         32'h0F0F0F0F);
    chk("post_err",   {31'h0, bus_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
